// File: rtl/seg_disp_scanner.sv
// seg_disp_scanner: multiplexed 7-segment scanner with double-buffered digit data and guard interval.
// Optional leading-zero blanking is compiled in when the macro SEG_DISP_LZB_EN is defined.
module seg_disp_scanner #(
   parameter int NUM_DIGITS     = 4,
   parameter int DIV            = 100000,
   parameter int GUARD          = 16,
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic                  addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata,
   output logic [7:0]            seg_o,
   output logic [NUM_DIGITS-1:0] an_o,
   output logic                  frame_o
);

   localparam int DW = 4 * NUM_DIGITS;
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [7:0] SEG_OFF = {8{SEG_ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_ACTIVE_LOW}};

   logic [PW-1:0]         prescQ, prescD;
   logic [IW-1:0]         idxQ, idxD;
   logic [DW-1:0]         stagingQ, stagingD;
   logic [DW-1:0]         shadowQ, shadowD;
   logic [7:0]            dpMaskQ, dpMaskD;
   logic [7:0]            blankMaskQ, blankMaskD;
   logic                  enableQ, enableD;
   logic                  lzbQ;
   logic [7:0]            segQ, segD;
   logic [NUM_DIGITS-1:0] anQ, anD;
   logic                  frameQ, frameD;

   logic                  slotEnd;
   logic                  frameEnd;
   logic                  inGuard;
   logic [3:0]            curNibble;
   logic                  curDp;
   logic                  curBlank;
   logic [NUM_DIGITS-1:0] anOn;
   logic [7:0]            segRaw;
   logic                  unusedBits;

   function automatic logic [6:0] hexFont(input logic [3:0] nib);
      case (nib)
         4'h0:    hexFont = 7'h3F;
         4'h1:    hexFont = 7'h06;
         4'h2:    hexFont = 7'h5B;
         4'h3:    hexFont = 7'h4F;
         4'h4:    hexFont = 7'h66;
         4'h5:    hexFont = 7'h6D;
         4'h6:    hexFont = 7'h7D;
         4'h7:    hexFont = 7'h07;
         4'h8:    hexFont = 7'h7F;
         4'h9:    hexFont = 7'h6F;
         4'hA:    hexFont = 7'h77;
         4'hB:    hexFont = 7'h7C;
         4'hC:    hexFont = 7'h39;
         4'hD:    hexFont = 7'h5E;
         4'hE:    hexFont = 7'h79;
         default: hexFont = 7'h71;
      endcase
   endfunction

   assign unusedBits = ^wdata[31:17];

   assign slotEnd  = (prescQ == PRESC_LAST);
   assign frameEnd = slotEnd && (idxQ == IDX_LAST);
   assign inGuard  = (int'(prescQ) < GUARD);

`ifdef SEG_DISP_LZB_EN
   logic [NUM_DIGITS-1:0] lzbMask;
   logic                  allZero;

   // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
   always_comb begin
      lzbMask = '0;
      allZero = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         allZero    = allZero & (shadowQ[4*i +: 4] == 4'h0);
         lzbMask[i] = allZero;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lzbQ <= 1'b0;
      end else if (we && addr) begin
         lzbQ <= wdata[17];
      end
   end
`else
   assign lzbQ = 1'b0;
`endif

   always_comb begin
      curNibble = 4'h0;
      curDp     = 1'b0;
      curBlank  = 1'b0;
      anOn      = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idxQ == IW'(i)) begin
            curNibble = shadowQ[4*i +: 4];
            curDp     = dpMaskQ[i];
            curBlank  = blankMaskQ[i];
            anOn[i]   = 1'b1;
`ifdef SEG_DISP_LZB_EN
            if (lzbQ && lzbMask[i]) begin
               curBlank = 1'b1;
            end
`endif
         end
      end
   end

   // Pins are dark during the guard interval so the previous digit's segments cannot ghost.
   always_comb begin
      segRaw = 8'h00;
      segD   = SEG_OFF;
      anD    = AN_OFF;
      if (enableQ && !inGuard) begin
         segRaw = {curDp, curBlank ? 7'h00 : hexFont(curNibble)};
         segD   = SEG_ACTIVE_LOW ? ~segRaw : segRaw;
         anD    = AN_ACTIVE_LOW ? ~anOn : anOn;
      end
   end

   // The shadow captures staging before a same-edge DATA write lands, so that write waits a frame.
   always_comb begin
      prescD     = slotEnd ? '0 : prescQ + 1'b1;
      idxD       = idxQ;
      if (slotEnd) begin
         idxD = (idxQ == IDX_LAST) ? '0 : idxQ + 1'b1;
      end
      shadowD    = frameEnd ? stagingQ : shadowQ;
      frameD     = frameEnd;
      stagingD   = stagingQ;
      dpMaskD    = dpMaskQ;
      blankMaskD = blankMaskQ;
      enableD    = enableQ;
      if (we) begin
         if (!addr) begin
            stagingD = wdata[DW-1:0];
         end else begin
            dpMaskD    = wdata[7:0];
            blankMaskD = wdata[15:8];
            enableD    = wdata[16];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prescQ     <= '0;
         idxQ       <= '0;
         stagingQ   <= '0;
         shadowQ    <= '0;
         dpMaskQ    <= 8'h00;
         blankMaskQ <= 8'h00;
         enableQ    <= 1'b0;
         segQ       <= SEG_OFF;
         anQ        <= AN_OFF;
         frameQ     <= 1'b0;
      end else begin
         prescQ     <= prescD;
         idxQ       <= idxD;
         stagingQ   <= stagingD;
         shadowQ    <= shadowD;
         dpMaskQ    <= dpMaskD;
         blankMaskQ <= blankMaskD;
         enableQ    <= enableD;
         segQ       <= segD;
         anQ        <= anD;
         frameQ     <= frameD;
      end
   end

   always_comb begin
      rdata = '0;
      if (addr) begin
         rdata[17:0] = {lzbQ, enableQ, blankMaskQ, dpMaskQ};
      end else begin
         rdata[DW-1:0] = stagingQ;
      end
   end

   assign seg_o   = segQ;
   assign an_o    = anQ;
   assign frame_o = frameQ;

endmodule

// File: tb/tb_seg_disp_scanner.sv
// tb_seg_disp_scanner: vector table, hand sequences and random traffic against a slot-position model.
// Build with SEG_DISP_LZB_EN defined to cover leading-zero blanking.
`timescale 1ns/1ps
module tb_seg_disp_scanner;

   localparam int ND    = 4;
   localparam int DIVP  = 8;
   localparam int GRD   = 2;
   localparam int FRAME = ND * DIVP;
`ifdef SEG_DISP_LZB_EN
   localparam logic [31:0] CTRL_MASK = 32'h0003FFFF;
   localparam bit LZB_ON = 1'b1;
`else
   localparam logic [31:0] CTRL_MASK = 32'h0001FFFF;
   localparam bit LZB_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we = 1'b0;
   logic        addr = 1'b0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic [7:0]  seg;
   logic [3:0]  an;
   logic        frame;

   always #5 clk = ~clk;

   seg_disp_scanner #(
      .NUM_DIGITS(ND), .DIV(DIVP), .GUARD(GRD), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .seg_o(seg), .an_o(an), .frame_o(frame)
   );

   int testsRun = 0;
   int testsFailed = 0;

   // Model: mK counts edges since reset, so the scanner sits at slot position mK.
   int          mK = 0;
   logic [15:0] mStaging = 16'h0;
   logic [15:0] mShadow = 16'h0;
   logic [31:0] mCtrl = 32'h0;
   logic [3:0]  expAn = 4'hF;
   logic [7:0]  expSeg = 8'h00;
   logic        expFrame = 1'b0;
   logic [6:0]  font [16];

   typedef struct {
      logic [15:0] data;
      logic [31:0] ctrl;
      int          digit;
      logic [3:0]  expAn;
      logic [7:0]  expSeg;
   } vec_t;
   vec_t vecs[$];

   function automatic void modelPins(input int pos, input logic [15:0] shadow, input logic [31:0] ctrl,
                                     output logic [3:0] a, output logic [7:0] s);
      int digit;
      int phase;
      logic [3:0] nib;
      logic blank;
      digit = (pos / DIVP) % ND;
      phase = pos % DIVP;
      a = 4'hF;
      s = 8'h00;
      if (ctrl[16] && phase >= GRD) begin
         nib   = 4'((shadow >> (4 * digit)) & 16'hF);
         blank = ctrl[8 + digit] || (LZB_ON && ctrl[17] && digit != 0 && (shadow >> (4 * digit)) == 16'h0);
         a     = ~(4'b0001 << digit);
         s     = {ctrl[digit], blank ? 7'h00 : font[nib]};
      end
   endfunction

   task automatic modelEdge();
      if (rst) begin
         mK = 0;
         mStaging = 16'h0;
         mShadow = 16'h0;
         mCtrl = 32'h0;
         expAn = 4'hF;
         expSeg = 8'h00;
         expFrame = 1'b0;
      end else begin
         modelPins(mK, mShadow, mCtrl, expAn, expSeg);
         mK++;
         expFrame = (mK % FRAME == 0);
         if (expFrame) mShadow = mStaging;
         if (we) begin
            if (!addr) mStaging = wdata[15:0];
            else mCtrl = wdata & CTRL_MASK;
         end
      end
   endtask

   task automatic checkOutput();
      logic [31:0] expRd;
      expRd = addr ? mCtrl : {16'h0, mStaging};
      testsRun++;
      if ({an, seg, frame} !== {expAn, expSeg, expFrame}) begin
         testsFailed++;
         $display("[TB] FAIL pins pos=%0d: an=%h seg=%h frame=%b, expected an=%h seg=%h frame=%b",
                  mK, an, seg, frame, expAn, expSeg, expFrame);
      end
      testsRun++;
      if (rdata !== expRd) begin
         testsFailed++;
         $display("[TB] FAIL rdata addr=%b: got %h, expected %h", addr, rdata, expRd);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic w, input logic a, input logic [31:0] d);
      rst = r;
      we = w;
      addr = a;
      wdata = d;
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput();
      rst = 1'b0;
      we = 1'b0;
   endtask

   task automatic checkConst(input string name, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, addr, 32'h0);
   endtask

   task automatic waitFrame(output int steps);
      steps = 0;
      do begin
         applyStimulus(1'b0, 1'b0, addr, 32'h0);
         steps++;
      end while (frame !== 1'b1 && steps < 200);
      if (frame !== 1'b1) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL frameTimeout: got no frame pulse, expected one within 200 cycles");
      end
   endtask

   task automatic writeRegs(input logic [15:0] data, input logic [31:0] ctrl);
      applyStimulus(1'b0, 1'b1, 1'b0, {16'h0, data});
      applyStimulus(1'b0, 1'b1, 1'b1, ctrl);
   endtask

   initial begin
      int n;
      int frames;
      logic anyLit;
      logic r;
      logic w;
      logic a;
      logic [31:0] d;

      font = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

      vecs.push_back('{16'h1234, 32'h00010000, 0, 4'hE, 8'h66});
      vecs.push_back('{16'h1234, 32'h00010000, 1, 4'hD, 8'h4F});
      vecs.push_back('{16'h1234, 32'h00010000, 2, 4'hB, 8'h5B});
      vecs.push_back('{16'h1234, 32'h00010000, 3, 4'h7, 8'h06});
      vecs.push_back('{16'hABCD, 32'h00010000, 0, 4'hE, 8'h5E});
      vecs.push_back('{16'hABCD, 32'h00010000, 1, 4'hD, 8'h39});
      vecs.push_back('{16'hABCD, 32'h00010000, 2, 4'hB, 8'h7C});
      vecs.push_back('{16'hABCD, 32'h00010000, 3, 4'h7, 8'h77});
      vecs.push_back('{16'h1234, 32'h00010205, 0, 4'hE, 8'hE6});
      vecs.push_back('{16'h1234, 32'h00010205, 1, 4'hD, 8'h00});
      vecs.push_back('{16'h1234, 32'h00010205, 2, 4'hB, 8'hDB});
      vecs.push_back('{16'h5678, 32'h000000FF, 1, 4'hF, 8'h00});
      vecs.push_back('{16'h5678, 32'h0001FF0F, 2, 4'hB, 8'h80});
`ifdef SEG_DISP_LZB_EN
      vecs.push_back('{16'h0040, 32'h00030000, 3, 4'h7, 8'h00});
      vecs.push_back('{16'h0040, 32'h00030000, 2, 4'hB, 8'h00});
      vecs.push_back('{16'h0040, 32'h00030000, 1, 4'hD, 8'h66});
      vecs.push_back('{16'h0040, 32'h00030000, 0, 4'hE, 8'h3F});
      vecs.push_back('{16'h0000, 32'h00030000, 1, 4'hD, 8'h00});
      vecs.push_back('{16'h0000, 32'h00030000, 0, 4'hE, 8'h3F});
`else
      vecs.push_back('{16'h0040, 32'h00030000, 3, 4'h7, 8'h3F});
      vecs.push_back('{16'h0040, 32'h00030000, 1, 4'hD, 8'h66});
`endif

      // Reset, then the display stays dark while disabled and frames still tick.
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkConst("reset an", an, 4'hF);
      checkConst("reset seg", seg, 8'h00);
      checkConst("reset frame", frame, 0);
      frames = 0;
      anyLit = 1'b0;
      repeat (64) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
         if (frame === 1'b1) frames++;
         if (an !== 4'hF || seg !== 8'h00) anyLit = 1'b1;
      end
      checkConst("disabled frames", frames, 2);
      checkConst("disabled dark", anyLit, 0);

      // Guard interval then six ON cycles for digit 0.
      writeRegs(16'h1234, 32'h00010000);
      waitFrame(n);
      idle(2);
      checkConst("guard an", an, 4'hF);
      idle(1);
      checkConst("slot0 first an", an, 4'hE);
      checkConst("slot0 first seg", seg, 8'h66);
      idle(5);
      checkConst("slot0 last an", an, 4'hE);
      idle(1);
      checkConst("slot1 guard an", an, 4'hF);

      // Mid-frame DATA write is held off until the next frame.
      waitFrame(n);
      idle(3);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000ABCD);
      idle(25);
      checkConst("midframe old digit3", seg, 8'h06);
      waitFrame(n);
      idle(5);
      checkConst("midframe new digit0", seg, 8'h5E);

      // DATA write landing on the boundary edge shows only one frame later.
      waitFrame(n);
      idle(FRAME - 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h00001234);
      checkConst("boundary frame", frame, 1);
      idle(5);
      checkConst("boundary held digit0", seg, 8'h5E);
      waitFrame(n);
      idle(5);
      checkConst("boundary later digit0", seg, 8'h66);

      for (int i = 0; i < vecs.size(); i++) begin
         writeRegs(vecs[i].data, vecs[i].ctrl);
         waitFrame(n);
         idle(vecs[i].digit * DIVP + 5);
         checkConst($sformatf("vec%0d an", i), an, vecs[i].expAn);
         checkConst($sformatf("vec%0d seg", i), seg, vecs[i].expSeg);
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
      checkConst("ctrl readback", rdata, LZB_ON ? 32'h00030000 : 32'h00010000);

      // Reset in the middle of digit 2's ON phase.
      writeRegs(16'h1234, 32'h00010000);
      waitFrame(n);
      idle(2 * DIVP + 4);
      checkConst("pre-reset an", an, 4'hB);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkConst("post-reset an", an, 4'hF);
      checkConst("post-reset data", rdata, 32'h0);
      addr = 1'b1;
      #1;
      checkConst("post-reset ctrl", rdata, 32'h0);
      waitFrame(n);
      checkConst("post-reset frame distance", n, FRAME);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 599) == 0);
         w = ($urandom_range(0, 7) == 0);
         a = 1'($urandom_range(0, 1));
         d = $urandom;
         if (a && $urandom_range(0, 3) != 0) d[16] = 1'b1;
         if (a && $urandom_range(0, 1) == 0) d[15:8] = 8'h00;
         if (!a && $urandom_range(0, 2) == 0) d[15:8] = 8'h00;
         applyStimulus(r, w, a, d);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
